// File: rtl/cmos_pkg.sv
// Shared definitions for the CMOS camera capture block: capture FSM states
// and the width of the captured-frame counter.
package cmos_pkg;

    localparam int FRAME_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_SKIP     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_FRAME    = 2'd2
    } cap_state_e;

endpackage

// File: rtl/pix_pack.sv
// pix_pack: shifts camera bytes into a pixel, first byte of a pixel in the MSBs.
// Latency: pix_dat/pix_vld are combinational in the cycle the final byte is presented.
// Backpressure: none; clr drops a partially assembled pixel.
module pix_pack #(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            byte_vld,
    input  logic                            clr,
    input  logic [DATA_W-1:0]               byte_dat,
    output logic [DATA_W*BYTES_PER_PIX-1:0] pix_dat,
    output logic                            pix_vld,
    output logic                            partial
);

    localparam int PIX_W = DATA_W * BYTES_PER_PIX;
    localparam int CNT_W = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES_PER_PIX - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign pix_vld = byte_vld && (cnt_q == LAST);
    assign partial = (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || pix_vld) begin
            cnt_d = '0;
        end else if (byte_vld) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Older bytes simply fall off the top, so no explicit clear of the shifter is needed.
    generate
        if (BYTES_PER_PIX == 1) begin : g_single
            assign pix_dat = byte_dat;
        end else begin : g_multi
            logic [PIX_W-DATA_W-1:0] shift_q;
            assign pix_dat = {shift_q, byte_dat};
            always_ff @(posedge clk) begin
                if (rst) begin
                    shift_q <= '0;
                end else if (byte_vld) begin
                    shift_q <= pix_dat[PIX_W-DATA_W-1:0];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/cmos_capture.sv
// cmos_capture: camera capture with settle-skip and format checks; CMOS_CAPTURE_CROP_EN enables the crop window.
// Latency: pix_valid rises 2 clk after the final byte of a pixel is on cam_data.
// Backpressure: none; the sensor cannot be stalled, pixels stream at bus rate.
module cmos_capture
    import cmos_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int H_ACT         = 640,
    parameter int V_ACT         = 480,
    parameter int SKIP_FRAMES   = 10,
    parameter int CROP_X0       = 0,
    parameter int CROP_Y0       = 0,
    parameter int CROP_W        = 640,
    parameter int CROP_H        = 480
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cap_en,
    input  logic                            cam_href,
    input  logic                            cam_vsync,
    input  logic [DATA_W-1:0]               cam_data,
    output logic [DATA_W*BYTES_PER_PIX-1:0] pix_data,
    output logic                            pix_valid,
    output logic                            pix_sof,
    output logic                            pix_eol,
    output logic                            frame_done,
    output logic [FRAME_CNT_W-1:0]          frame_cnt,
    output logic                            fmt_err
);

    localparam int PIX_W = DATA_W * BYTES_PER_PIX;
    localparam int X_W   = $clog2(H_ACT + 2);
    localparam int Y_W   = $clog2(V_ACT + 2);
    localparam int SK_W  = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;

`ifdef CMOS_CAPTURE_CROP_EN
    localparam int WIN_X0 = CROP_X0;
    localparam int WIN_Y0 = CROP_Y0;
    localparam int WIN_X1 = (CROP_X0 + CROP_W < H_ACT) ? CROP_X0 + CROP_W : H_ACT;
    localparam int WIN_Y1 = (CROP_Y0 + CROP_H < V_ACT) ? CROP_Y0 + CROP_H : V_ACT;
`else
    localparam int WIN_X0 = 0;
    localparam int WIN_Y0 = 0;
    localparam int WIN_X1 = H_ACT;
    localparam int WIN_Y1 = V_ACT;
`endif

    logic                   href_q, href_qq, vsync_q, vsync_qq;
    logic [DATA_W-1:0]      data_q;
    cap_state_e             state_q, state_d;
    logic [SK_W-1:0]        skip_q, skip_d;
    logic [X_W-1:0]         x_q, x_d;
    logic [Y_W-1:0]         y_q, y_d;
    logic                   sof_pend_q, sof_pend_d;
    logic [PIX_W-1:0]       pix_data_q, pix_data_d;
    logic                   pix_valid_q, pix_valid_d;
    logic                   pix_sof_q, pix_sof_d;
    logic                   pix_eol_q, pix_eol_d;
    logic                   frame_done_q, frame_done_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   fmt_err_q, fmt_err_d;

    logic             vs_fall, vs_rise, href_fall;
    logic             pk_clr, pk_vld, pk_partial, byte_vld;
    logic [PIX_W-1:0] pk_dat;
    logic             in_win, at_eol;

    assign vs_fall   = vsync_qq & ~vsync_q;
    assign vs_rise   = vsync_q & ~vsync_qq;
    assign href_fall = href_qq & ~href_q;
    assign byte_vld  = (state_q == ST_FRAME) && href_q;

    // x/y saturate one past the active size so over-long lines/frames stay detectable.
    assign in_win = (int'(x_q) >= WIN_X0) && (int'(x_q) < WIN_X1) &&
                    (int'(y_q) >= WIN_Y0) && (int'(y_q) < WIN_Y1);
    assign at_eol = (int'(x_q) == WIN_X1 - 1);

    pix_pack #(
        .DATA_W        (DATA_W),
        .BYTES_PER_PIX (BYTES_PER_PIX)
    ) u_pix_pack (
        .clk      (clk),
        .rst      (rst),
        .byte_vld (byte_vld),
        .clr      (pk_clr),
        .byte_dat (data_q),
        .pix_dat  (pk_dat),
        .pix_vld  (pk_vld),
        .partial  (pk_partial)
    );

    always_comb begin
        state_d      = state_q;
        skip_d       = skip_q;
        x_d          = x_q;
        y_d          = y_q;
        sof_pend_d   = sof_pend_q;
        pix_data_d   = pix_data_q;
        pix_valid_d  = 1'b0;
        pix_sof_d    = 1'b0;
        pix_eol_d    = 1'b0;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        fmt_err_d    = fmt_err_q;
        pk_clr       = 1'b0;
        unique case (state_q)
            ST_SKIP: begin
                if (SKIP_FRAMES == 0) begin
                    state_d = ST_WAIT_SOF;
                end else if (vs_fall) begin
                    if (skip_q == SK_W'(SKIP_FRAMES - 1)) begin
                        state_d = ST_WAIT_SOF;
                    end else begin
                        skip_d = skip_q + 1'b1;
                    end
                end
            end
            ST_WAIT_SOF: begin
                if (vs_fall && cap_en) begin
                    state_d    = ST_FRAME;
                    x_d        = '0;
                    y_d        = '0;
                    sof_pend_d = 1'b1;
                    pk_clr     = 1'b1;
                end
            end
            ST_FRAME: begin
                if (pk_vld) begin
                    if (in_win) begin
                        pix_valid_d = 1'b1;
                        pix_data_d  = pk_dat;
                        pix_sof_d   = sof_pend_q;
                        pix_eol_d   = at_eol;
                        sof_pend_d  = 1'b0;
                    end
                    if (x_q <= X_W'(H_ACT)) x_d = x_q + 1'b1;
                end
                if (href_fall) begin
                    pk_clr = 1'b1;
                    x_d    = '0;
                    if (y_q <= Y_W'(V_ACT)) y_d = y_q + 1'b1;
                    if (pk_partial || (x_q != X_W'(H_ACT))) fmt_err_d = 1'b1;
                end
                if (vs_rise) begin
                    state_d      = ST_WAIT_SOF;
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 1'b1;
                    if ((y_q != Y_W'(V_ACT)) || href_q || pk_partial || (x_q != '0)) begin
                        fmt_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_SKIP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            href_q       <= 1'b0;
            href_qq      <= 1'b0;
            vsync_q      <= 1'b0;
            vsync_qq     <= 1'b0;
            data_q       <= '0;
            state_q      <= ST_SKIP;
            skip_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            sof_pend_q   <= 1'b0;
            pix_data_q   <= '0;
            pix_valid_q  <= 1'b0;
            pix_sof_q    <= 1'b0;
            pix_eol_q    <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            fmt_err_q    <= 1'b0;
        end else begin
            href_q       <= cam_href;
            href_qq      <= href_q;
            vsync_q      <= cam_vsync;
            vsync_qq     <= vsync_q;
            data_q       <= cam_data;
            state_q      <= state_d;
            skip_q       <= skip_d;
            x_q          <= x_d;
            y_q          <= y_d;
            sof_pend_q   <= sof_pend_d;
            pix_data_q   <= pix_data_d;
            pix_valid_q  <= pix_valid_d;
            pix_sof_q    <= pix_sof_d;
            pix_eol_q    <= pix_eol_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            fmt_err_q    <= fmt_err_d;
        end
    end

    assign pix_data   = pix_data_q;
    assign pix_valid  = pix_valid_q;
    assign pix_sof    = pix_sof_q;
    assign pix_eol    = pix_eol_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign fmt_err    = fmt_err_q;

endmodule

// File: tb/tb_cmos_capture.sv
// Randomised frame stimulus against a frame/line-level reference model; a
// scoreboard queue per output stream is drained by a free-running monitor.
module tb_cmos_capture;

    localparam int DATA_W = 8;
    localparam int BPP    = 2;
    localparam int H_ACT  = 4;
    localparam int V_ACT  = 3;
    localparam int SKIP   = 2;
    localparam int CX0    = 1;
    localparam int CY0    = 1;
    localparam int CW     = 2;
    localparam int CH     = 1;
    localparam int PIX_W  = DATA_W * BPP;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cap_en = 1'b1;
    logic              cam_href = 1'b0;
    logic              cam_vsync = 1'b1;
    logic [DATA_W-1:0] cam_data = '0;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_valid, pix_sof, pix_eol, frame_done, fmt_err;
    logic [15:0]       frame_cnt;

    cmos_capture #(
        .DATA_W(DATA_W), .BYTES_PER_PIX(BPP), .H_ACT(H_ACT), .V_ACT(V_ACT),
        .SKIP_FRAMES(SKIP), .CROP_X0(CX0), .CROP_Y0(CY0), .CROP_W(CW), .CROP_H(CH)
    ) dut (
        .clk(clk), .rst(rst), .cap_en(cap_en), .cam_href(cam_href),
        .cam_vsync(cam_vsync), .cam_data(cam_data), .pix_data(pix_data),
        .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_eol(pix_eol),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .fmt_err(fmt_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [PIX_W-1:0] dat; logic sof; logic eol; int cyc; } pix_exp_t;
    typedef struct { logic [15:0] cnt; logic err; int cyc; } frm_exp_t;

    pix_exp_t pix_q[$];
    frm_exp_t frm_q[$];
    int n_vec = 0;
    int n_bad = 0;

    int          m_skip;
    logic [15:0] m_cnt;
    logic        m_err;
    int          line_len[8];

    function automatic bit in_win(input int x, input int y);
        if (x >= H_ACT || y >= V_ACT) return 1'b0;
`ifdef CMOS_CAPTURE_CROP_EN
        return (x >= CX0) && (x < CX0 + CW) && (y >= CY0) && (y < CY0 + CH);
`else
        return 1'b1;
`endif
    endfunction

    function automatic int win_last_x();
`ifdef CMOS_CAPTURE_CROP_EN
        return ((CX0 + CW < H_ACT) ? CX0 + CW : H_ACT) - 1;
`else
        return H_ACT - 1;
`endif
    endfunction

    // Monitor: compares every DUT output cycle against the scoreboards.
    logic             rst_at_edge = 1'b0;
    bit               mon_on = 1'b0;
    logic [PIX_W-1:0] last_dat = '0;
    pix_exp_t         pe;
    frm_exp_t         fe;

    always @(posedge clk) rst_at_edge <= rst;

    always @(negedge clk) begin
        if (rst_at_edge) begin
            mon_on = 1'b1;
            n_vec++;
            if ({pix_data, pix_valid, pix_sof, pix_eol, frame_done, frame_cnt, fmt_err} !== '0) begin
                n_bad++;
                $display("FAIL reset_vals got data=%h v=%b sof=%b eol=%b fd=%b cnt=%0d err=%b want all zero",
                         pix_data, pix_valid, pix_sof, pix_eol, frame_done, frame_cnt, fmt_err);
            end
            last_dat = '0;
        end else if (mon_on) begin
            n_vec++;
            if (pix_valid === 1'b1) begin
                if (pix_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_pix got data=%h at cyc=%0d want no pixel", pix_data, cyc);
                end else begin
                    pe = pix_q.pop_front();
                    if (pix_data !== pe.dat || pix_sof !== pe.sof || pix_eol !== pe.eol || cyc != pe.cyc) begin
                        n_bad++;
                        $display("FAIL pix got data=%h sof=%b eol=%b cyc=%0d want data=%h sof=%b eol=%b cyc=%0d",
                                 pix_data, pix_sof, pix_eol, cyc, pe.dat, pe.sof, pe.eol, pe.cyc);
                    end
                end
                last_dat = pix_data;
            end else if (pix_valid !== 1'b0 || pix_data !== last_dat) begin
                n_bad++;
                $display("FAIL hold got v=%b data=%h want v=0 data=%h", pix_valid, pix_data, last_dat);
            end
            if (frame_done !== 1'b0) begin
                n_vec++;
                if (frm_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_frame_done got fd=%b cnt=%0d at cyc=%0d want none", frame_done, frame_cnt, cyc);
                end else begin
                    fe = frm_q.pop_front();
                    if (frame_cnt !== fe.cnt || fmt_err !== fe.err || cyc != fe.cyc) begin
                        n_bad++;
                        $display("FAIL frame got cnt=%0d err=%b cyc=%0d want cnt=%0d err=%b cyc=%0d",
                                 frame_cnt, fmt_err, cyc, fe.cnt, fe.err, fe.cyc);
                    end
                end
            end
        end
    end

    task automatic tick(input logic h, input logic v, input logic [DATA_W-1:0] d);
        cam_href  = h;
        cam_vsync = v;
        cam_data  = d;
        @(posedge clk);
        #1;
    endtask

    // rl: line in which rst is pulsed on its second byte (-1 = none).
    task automatic send_frame(input int nl, input int rl, input bit chg, input logic nxt);
        bit               cap, dead, sof_left;
        logic [PIX_W-1:0] acc;
        logic [DATA_W-1:0] bt;
        int               c0;
        pix_exp_t         e;
        frm_exp_t         f;
        repeat (3) tick(1'b0, 1'b1, '0);
        if (m_skip > 0) begin
            m_skip--;
            cap = 1'b0;
        end else begin
            cap = cap_en;
        end
        dead = 1'b0;
        sof_left = 1'b1;
        acc = '0;
        repeat (2) tick(1'b0, 1'b0, '0);
        for (int l = 0; l < nl; l++) begin
            if (l == 1 && chg) cap_en = nxt;
            for (int b = 0; b < line_len[l]; b++) begin
                bt  = DATA_W'($urandom);
                acc = (acc << DATA_W) | PIX_W'(bt);
                if (l == rl && b == 1) begin
                    rst    = 1'b1;
                    dead   = 1'b1;
                    m_skip = SKIP;
                    m_cnt  = '0;
                    m_err  = 1'b0;
                end
                c0 = cyc;
                tick(1'b1, 1'b0, bt);
                rst = 1'b0;
                if (cap && !dead && (b % BPP == BPP - 1) && in_win(b / BPP, l)) begin
                    e.dat = acc;
                    e.sof = sof_left;
                    e.eol = ((b / BPP) == win_last_x());
                    e.cyc = c0 + 2;
                    pix_q.push_back(e);
                    sof_left = 1'b0;
                end
            end
            if (cap && !dead && ((line_len[l] % BPP != 0) || (line_len[l] / BPP != H_ACT))) m_err = 1'b1;
            repeat (2 + $urandom_range(0, 2)) tick(1'b0, 1'b0, '0);
        end
        tick(1'b0, 1'b0, '0);
        c0 = cyc;
        tick(1'b0, 1'b1, '0);
        if (cap && !dead) begin
            m_cnt++;
            if (nl != V_ACT) m_err = 1'b1;
            f.cnt = m_cnt;
            f.err = m_err;
            f.cyc = c0 + 2;
            frm_q.push_back(f);
        end
    endtask

    task automatic clean_frame(input bit chg, input logic nxt);
        for (int l = 0; l < 8; l++) line_len[l] = H_ACT * BPP;
        send_frame(V_ACT, -1, chg, nxt);
    endtask

    task automatic rand_frame(input bit chg, input logic nxt);
        int nl;
        nl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(V_ACT - 1, V_ACT + 1)) : V_ACT;
        for (int l = 0; l < 8; l++) begin
            line_len[l] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 2 * H_ACT * BPP)) : H_ACT * BPP;
        end
        send_frame(nl, -1, chg, nxt);
    endtask

    initial begin
        m_skip = SKIP;
        m_cnt  = '0;
        m_err  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;

        // Two settle frames are discarded, the third is captured clean.
        repeat (3) clean_frame(1'b0, 1'b1);
        // cap_en dropped mid-frame: this frame completes, the next is ignored.
        clean_frame(1'b1, 1'b0);
        clean_frame(1'b1, 1'b1);
        clean_frame(1'b0, 1'b1);

        // A 3-byte line yields one pixel and a sticky format error.
        for (int l = 0; l < 8; l++) line_len[l] = H_ACT * BPP;
        line_len[0] = 3;
        send_frame(V_ACT, -1, 1'b0, 1'b1);

        for (int i = 0; i < 8; i++) rand_frame($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);

        clean_frame(1'b1, 1'b1);
        clean_frame(1'b0, 1'b1);
        // Reset in the middle of line 1: no frame_done, skip sequence restarts.
        for (int l = 0; l < 8; l++) line_len[l] = H_ACT * BPP;
        send_frame(V_ACT, 1, 1'b0, 1'b1);
        repeat (3) clean_frame(1'b0, 1'b1);

        repeat (10) tick(1'b0, 1'b1, '0);

        n_vec++;
        if (pix_q.size() != 0) begin
            n_bad++;
            $display("FAIL pix_drain got %0d pixels outstanding want 0", pix_q.size());
        end
        n_vec++;
        if (frm_q.size() != 0) begin
            n_bad++;
            $display("FAIL frame_drain got %0d frames outstanding want 0", frm_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
